// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the co-simulation deadlock monitor.
// Stall FSM encoding, default sizing and the per-direction stall predicate.
package aesl_deadlock_pkg;

    typedef logic [1:0] stall_state_t;

    localparam stall_state_t ST_IDLE     = 2'd0;
    localparam stall_state_t ST_STALLING = 2'd1;
    localparam stall_state_t ST_BLOCKED  = 2'd2;

    localparam int DEF_CNT_W        = 16;
    localparam int DEF_STALL_THRESH = 16;

    // An input stream stalls when the DUT is ready but starved; an output
    // stream stalls when the DUT offers data the sink will not take.
    function automatic logic stall_cond(input logic is_input,
                                        input logic tvalid,
                                        input logic tready);
        return is_input ? (tready & ~tvalid) : (tvalid & ~tready);
    endfunction

endpackage

// File: rtl/aesl_axis_stall_ch.sv
// One channel's IDLE/STALLING/BLOCKED tracker; blocked asserts the cycle after
// the STALL_THRESH-th consecutive stall edge and drops one edge after progress.
module aesl_axis_stall_ch
    import aesl_deadlock_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STALL_THRESH = DEF_STALL_THRESH
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic stall,
    output logic blocked,
    output logic blocked_nxt,
    output logic enter_block
);

    localparam logic [CNT_W-1:0] THRESH = CNT_W'(STALL_THRESH);

    stall_state_t     state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_W'(1);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!enable) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (stall) begin
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = (STALL_THRESH == 1) ? ST_BLOCKED : ST_STALLING;
                    end
                end
                ST_STALLING: begin
                    if (stall) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc == THRESH) begin
                            state_nxt = ST_BLOCKED;
                        end
                    end else begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                ST_BLOCKED: begin
                    // Counter holds while blocked so it can never wrap.
                    if (!stall) begin
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign blocked     = (state == ST_BLOCKED);
    assign blocked_nxt = (state_nxt == ST_BLOCKED);
    assign enter_block = blocked_nxt & ~blocked;

endmodule

// File: rtl/aesl_axis_stall_detector.sv
// Per-stream AXI-Stream stall detector feeding the deadlock monitor, with sticky diagnostics.
// All outputs registered; purely observes handshakes and never back-pressures the streams.
module aesl_axis_stall_detector
    import aesl_deadlock_pkg::*;
#(
    parameter int                NUM_CH       = 2,
    parameter logic [NUM_CH-1:0] CH_IS_INPUT  = 2'b01,
    parameter int                STALL_THRESH = DEF_STALL_THRESH,
    parameter int                CNT_W        = DEF_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_tvalid,
    input  logic [NUM_CH-1:0] ch_tready,
    input  logic              clear_sticky,
    output logic [NUM_CH-1:0] axis_block_sigs,
    output logic              any_block,
    output logic [NUM_CH-1:0] first_blocked,
    output logic [CNT_W-1:0]  block_events
);

    logic [NUM_CH-1:0] blocked;
    logic [NUM_CH-1:0] blocked_nxt;
    logic [NUM_CH-1:0] enter_block;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        aesl_axis_stall_ch #(
            .CNT_W        (CNT_W),
            .STALL_THRESH (STALL_THRESH)
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .enable      (enable),
            .stall       (stall_cond(CH_IS_INPUT[i], ch_tvalid[i], ch_tready[i])),
            .blocked     (blocked[i]),
            .blocked_nxt (blocked_nxt[i]),
            .enter_block (enter_block[i])
        );
    end

    assign axis_block_sigs = blocked;

    // One extra bit catches overflow so the counter can pin at all-ones.
    logic [CNT_W:0]   ev_sum;
    logic [CNT_W-1:0] ev_nxt;

    always_comb begin
        ev_sum = {1'b0, block_events} + (CNT_W+1)'($countones(enter_block));
        ev_nxt = ev_sum[CNT_W] ? '1 : ev_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            any_block <= 1'b0;
        end else begin
            any_block <= |blocked_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear_sticky) begin
            first_blocked <= '0;
            block_events  <= '0;
        end else begin
            if (first_blocked == '0) begin
                first_blocked <= enter_block;
            end
            block_events <= ev_nxt;
        end
    end

endmodule

// File: tb/tb_aesl_axis_stall_detector.sv
// Directed bench for aesl_axis_stall_detector with STALL_THRESH = 4 and hand-computed expectations.
module tb_aesl_axis_stall_detector;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [1:0]  ch_tvalid;
    logic [1:0]  ch_tready;
    logic        clear_sticky;
    logic [1:0]  axis_block_sigs;
    logic        any_block;
    logic [1:0]  first_blocked;
    logic [15:0] block_events;

    int n_assert = 0;
    int n_fail   = 0;

    aesl_axis_stall_detector #(
        .NUM_CH       (2),
        .CH_IS_INPUT  (2'b01),
        .STALL_THRESH (4),
        .CNT_W        (16)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .ch_tvalid       (ch_tvalid),
        .ch_tready       (ch_tready),
        .clear_sticky    (clear_sticky),
        .axis_block_sigs (axis_block_sigs),
        .any_block       (any_block),
        .first_blocked   (first_blocked),
        .block_events    (block_events)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] blk, input logic [1:0] fb,
                             input logic [15:0] ev);
        check({tag, ".blk"}, 32'(axis_block_sigs), 32'(blk));
        check({tag, ".any"}, 32'(any_block), 32'(|blk));
        check({tag, ".first"}, 32'(first_blocked), 32'(fb));
        check({tag, ".events"}, 32'(block_events), 32'(ev));
    endtask

    // Both channels non-stalling: ch0 tready=0, ch1 tvalid=0.
    task automatic idle();
        ch_tvalid = 2'b00;
        ch_tready = 2'b00;
    endtask

    task automatic clear_pulse();
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        clear_sticky = 1'b0;
        idle();
        step();
        step();
        check_all("reset", 2'b00, 2'b00, 16'd0);
        reset = 1'b0;

        // Ch0 starved for 4 edges.
        ch_tready = 2'b01;
        for (int i = 1; i <= 3; i++) begin
            step();
            check("s1.pre", 32'(axis_block_sigs), 32'd0);
        end
        step();
        check_all("s1.blocked", 2'b01, 2'b01, 16'd1);
        idle();
        step();
        check_all("s1.release", 2'b00, 2'b01, 16'd1);
        clear_pulse();
        check_all("s1.clear", 2'b00, 2'b00, 16'd0);

        // 3 stalls, a transfer, 3 stalls: never blocks.
        ch_tready = 2'b01;
        ch_tvalid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s2.a", 32'(axis_block_sigs), 32'd0);
        end
        ch_tvalid = 2'b01;
        step();
        check("s2.xfer", 32'(axis_block_sigs), 32'd0);
        ch_tvalid = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s2.b", 32'(axis_block_sigs), 32'd0);
        end
        idle();
        step();
        check_all("s2.end", 2'b00, 2'b00, 16'd0);

        // Ch1 back-pressured for 6 edges, then the sink accepts.
        ch_tvalid = 2'b10;
        ch_tready = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            step();
            check("s3.stall", 32'(axis_block_sigs), (i >= 4) ? 32'd2 : 32'd0);
        end
        ch_tready = 2'b10;
        step();
        check_all("s3.release", 2'b00, 2'b10, 16'd1);
        idle();
        clear_pulse();

        // Both channels stall together.
        ch_tvalid = 2'b10;
        ch_tready = 2'b01;
        for (int i = 0; i < 3; i++) step();
        check("s4.pre", 32'(axis_block_sigs), 32'd0);
        step();
        check_all("s4.both", 2'b11, 2'b11, 16'd2);
        idle();
        clear_pulse();

        // Enable drop while ch0 is blocked, then re-block.
        ch_tready = 2'b01;
        for (int i = 0; i < 4; i++) step();
        check_all("s5.blocked", 2'b01, 2'b01, 16'd1);
        enable = 1'b0;
        step();
        check_all("s5.disabled", 2'b00, 2'b01, 16'd1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("s5.pre", 32'(axis_block_sigs), 32'd0);
        step();
        check_all("s5.reblock", 2'b01, 2'b01, 16'd2);
        idle();
        step();

        // Reset in the middle of a stall; stall held through and after reset.
        ch_tready = 2'b01;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        check_all("s6.in_reset", 2'b00, 2'b00, 16'd0);
        step();
        check_all("s6.in_reset2", 2'b00, 2'b00, 16'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s6.pre", 32'(axis_block_sigs), 32'd0);
        end
        step();
        check_all("s6.blocked", 2'b01, 2'b01, 16'd1);
        idle();
        step();
        clear_pulse();

        // Clear coinciding with a block entry: the entry is lost from the sticky state.
        ch_tready = 2'b01;
        for (int i = 0; i < 3; i++) step();
        clear_sticky = 1'b1;
        step();
        clear_sticky = 1'b0;
        check_all("s7.clear_wins", 2'b01, 2'b00, 16'd0);
        step();
        check_all("s7.held", 2'b01, 2'b00, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
